serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Controller that sequences a single 1-bit full-adder cell (two half adders plus an OR on the carries) over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Sits between the lab's adder cells and any requester that needs a multi-bit add with minimal area.
- Provides a start/busy/done handshake, an operand load, a carry flip-flop between bit slices, and registered result outputs.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion clears all state immediately.
- start  input  1  request strobe; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse, high only in the DONE state.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered carry-out; holds its value until the next completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand, shift, carry and counter registers are cleared.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - If start=1 at a rising edge: load op_a<=a, op_b<=b, carry<=cin, acc<=0, cnt<=0, then go to RUN.
  - If start=0: stay in IDLE.
- RUN, one bit per cycle:
  - s = op_a[0]^op_b[0]^carry.
  - c = (op_a[0]&op_b[0]) | (carry&(op_a[0]^op_b[0])).
  - acc <= {s, acc[WIDTH-1:1]}; op_a and op_b shift right 1; carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge (last bit): go to DONE.
  - Exactly WIDTH cycles are spent in RUN.
- DONE:
  - sum<=acc and cout<=carry are loaded on entry, so they are valid while done=1.
  - done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - start accepted at edge E0 -> done high during the cycle after edge E0+WIDTH.
  - A new start can be accepted at the edge that leaves DONE+1, i.e. WIDTH+2 cycles per add.
- start while busy=1 (RUN or DONE): ignored; it is neither queued nor allowed to corrupt operands.
- Changes on a, b or cin after acceptance: no effect on the result in progress.
- sum/cout: change only on entry to DONE or on reset; they stay stable during a subsequent RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no signed interpretation.
- Reset mid-RUN: immediate abort; the partial result is discarded, no done pulse, outputs read 0.
- WIDTH=1: RUN lasts one cycle; the generic logic must be used, with no special case.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulse -> busy high next cycle; done pulses 9 cycles after the start edge with sum=8'h00, cout=1.
- WIDTH=8, a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0; sum/cout still 8'h97/0 ten cycles later with start low.
- During RUN of 8'h10+8'h20, pulse start with a=8'hFF, b=8'hFF and toggle a/b every cycle -> result 8'h30, cout=0, exactly one done pulse.
- Start 8'hAA+8'h55, drop rst_n for 1 ns at RUN cycle 4 -> busy/done/sum/cout read 0 immediately and no done pulse; after release, 8'h01+8'h01 gives sum=8'h02.
- Back-to-back: hold start high continuously with 8'h03+8'h04 then 8'h80+8'h80 -> done pulses 10 cycles apart; results 8'h07/0, then 8'h00/1.
- WIDTH=1, a=1, b=1, cin=1 -> done 2 cycles after start with sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands LSB-first through one full-adder cell,
// one bit per cycle, with a start/busy/done handshake and registered results.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] op_a_q, op_b_q, acc_q, sum_q, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cout_q, busy_q, done_q, h_d, s_d, c_d;

    // Two half adders plus an OR; the new sum bit enters acc from the top.
    always_comb begin
        h_d   = op_a_q[0] ^ op_b_q[0];
        s_d   = h_d ^ carry_q;
        c_d   = (op_a_q[0] & op_b_q[0]) | (carry_q & h_d);
        acc_d = WIDTH'({s_d, acc_q} >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_a_q  <= a;
                    op_b_q  <= b;
                    carry_q <= cin;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    op_a_q  <= op_a_q >> 1;
                    op_b_q  <= op_b_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= c_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Results load with the last bit so they are valid throughout DONE.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_q   <= acc_d;
                        cout_q  <= c_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
